// File: rtl/calc_pkg.sv
// Shared types and sizing for the calculator datapath.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int CALC_WIDTH = 64;
  localparam int CALC_SLICE = 20;

  function automatic int calc_nslice(input int width, input int slice);
    return (width + slice - 1) / slice;
  endfunction

  localparam int CALC_NSLICE = calc_nslice(CALC_WIDTH, CALC_SLICE);
  localparam int CALC_IDX_W  = $clog2(CALC_NSLICE);

  typedef logic [CALC_IDX_W-1:0] slice_idx_t;

endpackage

// File: rtl/carry_look_ahead_adder_20.sv
// 20-bit adder built from five 4-bit carry-look-ahead groups, group carries rippled.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module carry_look_ahead_adder_20 (
  input  logic [19:0] a,
  input  logic [19:0] b,
  input  logic        c_in,
  output logic [19:0] sum,
  output logic        c_out
);

  logic [19:0] g;
  logic [19:0] p;
  logic [19:0] c;
  logic [5:0]  gc;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    gc    = '0;
    gc[0] = c_in;
    for (int k = 0; k < 5; k++) begin
      int b0;
      b0 = 4 * k;
      c[b0]     = gc[k];
      c[b0 + 1] = g[b0] | (p[b0] & gc[k]);
      c[b0 + 2] = g[b0 + 1] | (p[b0 + 1] & g[b0]) | (p[b0 + 1] & p[b0] & gc[k]);
      c[b0 + 3] = g[b0 + 2] | (p[b0 + 2] & g[b0 + 1]) | (p[b0 + 2] & p[b0 + 1] & g[b0])
                | (p[b0 + 2] & p[b0 + 1] & p[b0] & gc[k]);
      gc[k + 1] = g[b0 + 3] | (p[b0 + 3] & g[b0 + 2]) | (p[b0 + 3] & p[b0 + 2] & g[b0 + 1])
                | (p[b0 + 3] & p[b0 + 2] & p[b0 + 1] & g[b0])
                | (p[b0 + 3] & p[b0 + 2] & p[b0 + 1] & p[b0] & gc[k]);
    end
    sum   = p ^ c;
    c_out = gc[5];
  end

endmodule

// File: rtl/add_sub_64_seq.sv
// Multi-cycle 64-bit add/subtract over one 20-bit slice adder; ADD64_SEQ_FLAGS_EN builds overflow/zero.
// Latency: 4 clocks from operand acceptance to out_valid (one slice per clock).
// Backpressure: in_ready low while busy; result and flags held in DONE until out_ready.
module add_sub_64_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int SLICE = CALC_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NSLICE    = calc_nslice(WIDTH, SLICE);
  localparam int PADW      = NSLICE * SLICE;
  localparam int LAST_BITS = WIDTH - (NSLICE - 1) * SLICE;
  localparam bit LAST_FULL = (LAST_BITS == SLICE);
  localparam int CBIT      = LAST_FULL ? 0 : LAST_BITS;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [PADW-1:0]  a_pad, b_pad;
  slice_idx_t       idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] res_q, res_next;
  logic             carry_out_q;
  logic [SLICE-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;
  logic             last_slice;
  logic             final_carry;

  // Operands are zero-padded above the top bit after the subtract inversion.
  assign a_pad = PADW'(a_q);
  assign b_pad = PADW'(b_q);

  assign last_slice = (idx_q == slice_idx_t'(NSLICE - 1));

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == slice_idx_t'(i)) begin
        slice_a = a_pad[i*SLICE +: SLICE];
        slice_b = b_pad[i*SLICE +: SLICE];
      end
    end
  end

  carry_look_ahead_adder_20 u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  // Only bits that exist in the result are written; the padded top of the last slice is dropped.
  always_comb begin
    res_next = res_q;
    for (int i = 0; i < NSLICE; i++) begin
      for (int j = 0; j < SLICE; j++) begin
        int bi;
        bi = i * SLICE + j;
        if ((idx_q == slice_idx_t'(i)) && (bi < WIDTH)) begin
          res_next[bi] = slice_sum[j];
        end
      end
    end
  end

  // With zero padding, the carry out of the top result bit lands in the first padded sum bit.
  assign final_carry = LAST_FULL ? slice_cout : slice_sum[CBIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      res_q       <= '0;
      carry_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= op_sub ? ~op_b : op_b;
            carry_q <= op_sub;
            idx_q   <= '0;
          end
        end
        RUN: begin
          res_q   <= res_next;
          carry_q <= slice_cout;
          idx_q   <= idx_q + slice_idx_t'(1);
          if (last_slice) begin
            carry_out_q <= final_carry;
            idx_q       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = res_q;
  assign carry_out = carry_out_q;

`ifdef ADD64_SEQ_FLAGS_EN
  logic overflow_q, zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if ((state_q == RUN) && last_slice) begin
      overflow_q <= (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (res_next[WIDTH-1] ^ a_q[WIDTH-1]);
      zero_q     <= ~|res_next;
    end
  end

  assign overflow = overflow_q;
  assign zero     = zero_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_add_sub_64_seq.sv
// Directed bench for add_sub_64_seq; flag expectations follow ADD64_SEQ_FLAGS_EN.
module tb_add_sub_64_seq;

`ifdef ADD64_SEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  add_sub_64_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set for a single edge (block is expected to be idle).
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    tick();
    in_valid = 1'b0;
  endtask

  // Edges after acceptance until out_valid; saturates at 20 on a hang.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_hs in_ready=%b out_valid=%b need 1/0", in_ready, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (result !== 64'h0 || carry_out !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0)
      $display("FAIL reset_out result=%h c=%b ov=%b z=%b need all 0", result, carry_out, overflow, zero);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_small();
    int cyc;
    out_ready = 1'b1;
    send(64'd5, 64'd7, 1'b0);
    wait_done(cyc);
    total_cnt++;
    if (cyc !== 4) $display("FAIL add_small_latency got %0d need 4", cyc);
    else pass_cnt++;
    total_cnt++;
    if (result !== 64'd12 || carry_out !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0)
      $display("FAIL add_small result=%h c=%b ov=%b z=%b need c/0/0/0", result, carry_out, overflow, zero);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL add_small_one_cycle out_valid=%b in_ready=%b need 0/1", out_valid, in_ready);
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_cross_slice();
    logic [63:0] va [2] = '{64'h0000_0000_000F_FFFF, 64'h0000_00FF_FFFF_FFFF};
    logic [63:0] vr [2] = '{64'h0000_0000_0010_0000, 64'h0000_0100_0000_0000};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      send(va[i], 64'd1, 1'b0);
      wait_done(cyc);
      total_cnt++;
      if (cyc !== 4 || result !== vr[i] || carry_out !== 1'b0)
        $display("FAIL cross_slice[%0d] cyc=%0d result=%h c=%b need 4 %h 0", i, cyc, result, carry_out, vr[i]);
      else pass_cnt++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_sub();
    logic [63:0] va [2] = '{64'h1234_5678_9ABC_DEF0, 64'd3};
    logic [63:0] vb [2] = '{64'h1234_5678_9ABC_DEF0, 64'd5};
    logic [63:0] vr [2] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFE};
    logic        vc [2] = '{1'b1, 1'b0};
    logic        vz [2] = '{1'b1, 1'b0};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      send(va[i], vb[i], 1'b1);
      wait_done(cyc);
      total_cnt++;
      if (cyc !== 4 || result !== vr[i]) $display("FAIL sub_result[%0d] cyc=%0d result=%h need 4 %h", i, cyc, result, vr[i]);
      else pass_cnt++;
      total_cnt++;
      if (carry_out !== vc[i] || overflow !== 1'b0 || zero !== (vz[i] & FLAGS))
        $display("FAIL sub_flags[%0d] c=%b ov=%b z=%b need %b 0 %b", i, carry_out, overflow, zero, vc[i], vz[i] & FLAGS);
      else pass_cnt++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_overflow();
    logic [63:0] va [2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] vr [2] = '{64'h8000_0000_0000_0000, 64'h0};
    logic        vc [2] = '{1'b0, 1'b1};
    logic        vo [2] = '{1'b1, 1'b0};
    logic        vz [2] = '{1'b0, 1'b1};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      send(va[i], 64'd1, 1'b0);
      wait_done(cyc);
      total_cnt++;
      if (cyc !== 4 || result !== vr[i]) $display("FAIL ovf_result[%0d] cyc=%0d result=%h need 4 %h", i, cyc, result, vr[i]);
      else pass_cnt++;
      total_cnt++;
      if (carry_out !== vc[i] || overflow !== (vo[i] & FLAGS) || zero !== (vz[i] & FLAGS))
        $display("FAIL ovf_flags[%0d] c=%b ov=%b z=%b need %b %b %b", i, carry_out, overflow, zero, vc[i], vo[i] & FLAGS, vz[i] & FLAGS);
      else pass_cnt++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op_a      = 64'd100;
    op_b      = 64'd1;
    op_sub    = 1'b1;
    tick();
    // Keep requesting with different operands while busy: must be ignored.
    op_a   = 64'hDEAD_BEEF_0000_0000;
    op_b   = 64'h0123_4567_89AB_CDEF;
    op_sub = 1'b0;
    wait_done(cyc);
    total_cnt++;
    if (cyc !== 4 || result !== 64'd99 || carry_out !== 1'b1)
      $display("FAIL busy_result cyc=%0d result=%h c=%b need 4 63 1", cyc, result, carry_out);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 64'd99 || carry_out !== 1'b1)
        $display("FAIL hold[%0d] out_valid=%b in_ready=%b result=%h c=%b need 1 0 63 1", i, out_valid, in_ready, result, carry_out);
      else pass_cnt++;
    end
    op_a      = 64'd20;
    op_b      = 64'd22;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL release out_valid=%b in_ready=%b need 0 1", out_valid, in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    wait_done(cyc);
    total_cnt++;
    if (cyc !== 4 || result !== 64'd42 || carry_out !== 1'b0)
      $display("FAIL next_op cyc=%0d result=%h c=%b need 4 2a 0", cyc, result, carry_out);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    send(64'h0000_0000_0012_3456, 64'h0000_0000_0000_1111, 1'b0);
    tick();
    tick();
    total_cnt++;
    if (result !== 64'h0000_0000_0012_4567 || in_ready !== 1'b0)
      $display("FAIL partial result=%h in_ready=%b need 124567 0", result, in_ready);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (result !== 64'h0 || carry_out !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL mid_reset result=%h c=%b ov=%b z=%b ov_vld=%b in_ready=%b need 0 0 0 0 0 1",
               result, carry_out, overflow, zero, out_valid, in_ready);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    send(64'd3, 64'd4, 1'b0);
    wait_done(cyc);
    total_cnt++;
    if (cyc !== 4 || result !== 64'd7 || carry_out !== 1'b0)
      $display("FAIL after_reset cyc=%0d result=%h c=%b need 4 7 0", cyc, result, carry_out);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_small();
    test_cross_slice();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
